// File: rtl/updown_tick_counter_if.sv
// Control/status bundle between an FND display client and updown_tick_counter.
// The load/load_value preset pair exists only when CNT_LOAD_EN is defined.
interface updown_tick_counter_if #(
  parameter int WIDTH = 14
);
  logic             en;
  logic             clear;
  logic             up_down;
  logic             mode;
`ifdef CNT_LOAD_EN
  logic             load;
  logic [WIDTH-1:0] load_value;
`endif
  logic [WIDTH-1:0] count;
  logic [3:0]       dot_data;
  logic             tc;

  modport master (
    output en, clear, up_down, mode,
`ifdef CNT_LOAD_EN
    output load, load_value,
`endif
    input  count, dot_data, tc
  );

  modport slave (
    input  en, clear, up_down, mode,
`ifdef CNT_LOAD_EN
    input  load, load_value,
`endif
    output count, dot_data, tc
  );
endinterface

// File: rtl/updown_tick_counter.sv
// Up/down decimal event counter with tick prescaler, wrap/saturate bounds, tc pulse and blinking dot.
// Define CNT_LOAD_EN to enable the synchronous preset (load/load_value).
module updown_tick_counter #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int MAX_COUNT = 9999,
  parameter int WIDTH     = 14
) (
  input logic                  clk,
  input logic                  reset,
  updown_tick_counter_if.slave bus
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0]    PCNT_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]    PCNT_ONE  = PW'(1);
  localparam logic [PW-1:0]    PCNT_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]    PCNT_HALF = PW'(TICK_DIV / 2);
  localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX   = WIDTH'(MAX_COUNT);

  function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] value);
    logic [WIDTH-1:0] result;
    if (value > CNT_MAX) begin
      result = CNT_MAX;
    end else begin
      result = value;
    end
    return result;
  endfunction

  function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] cur,
                                                  input logic             up,
                                                  input logic             sat);
    logic [WIDTH-1:0] result;
    if (up) begin
      if (cur == CNT_MAX) begin
        result = sat ? CNT_MAX : CNT_ZERO;
      end else begin
        result = cur + CNT_ONE;
      end
    end else begin
      if (cur == CNT_ZERO) begin
        result = sat ? CNT_ZERO : CNT_MAX;
      end else begin
        result = cur - CNT_ONE;
      end
    end
    return result;
  endfunction

  function automatic logic at_terminal(input logic [WIDTH-1:0] cur, input logic up);
    logic result;
    if (up) begin
      result = (cur == CNT_MAX);
    end else begin
      result = (cur == CNT_ZERO);
    end
    return result;
  endfunction

  logic [PW-1:0]    pcnt_r;
  logic [PW-1:0]    pcnt_next_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_next_s;
  logic             tc_r;
  logic             tc_next_s;
  logic             tick_s;
  logic             blink_s;
  logic             load_s;
  logic [WIDTH-1:0] load_value_s;

`ifdef CNT_LOAD_EN
  assign load_s       = bus.load;
  assign load_value_s = clamp_to_max(bus.load_value);
`else
  assign load_s       = 1'b0;
  assign load_value_s = CNT_ZERO;
`endif

  assign tick_s = bus.en && (pcnt_r == PCNT_LAST);

  // Next-state selection: clear > load > tick > run/hold
  always_comb begin
    pcnt_next_s  = pcnt_r;
    count_next_s = count_r;
    tc_next_s    = 1'b0;
    if (bus.clear) begin
      pcnt_next_s  = PCNT_ZERO;
      count_next_s = CNT_ZERO;
    end else if (load_s) begin
      pcnt_next_s  = PCNT_ZERO;
      count_next_s = load_value_s;
    end else if (tick_s) begin
      pcnt_next_s  = PCNT_ZERO;
      count_next_s = step_count(count_r, bus.up_down, bus.mode);
      tc_next_s    = at_terminal(count_r, bus.up_down);
    end else if (bus.en) begin
      pcnt_next_s  = pcnt_r + PCNT_ONE;
    end else begin
      pcnt_next_s  = pcnt_r;
    end
  end

  // Prescaler, count and terminal-count registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_r  <= PCNT_ZERO;
      count_r <= CNT_ZERO;
      tc_r    <= 1'b0;
    end else begin
      pcnt_r  <= pcnt_next_s;
      count_r <= count_next_s;
      tc_r    <= tc_next_s;
    end
  end

  // Blink follows en directly; gating with reset keeps the dots dark while reset is held
  assign blink_s      = reset && bus.en && (pcnt_r < PCNT_HALF);
  assign bus.dot_data = {1'b0, blink_s, 2'b00};
  assign bus.count    = count_r;
  assign bus.tc       = tc_r;
endmodule
